// File: rtl/aurora_pkg.sv
// Shared definitions for the Aurora 8b/10b lane striper.
// Holds the K-character byte codes and the striper state encoding.
// Optional feature macro: AURORA_STRIPER_CC_EN (adds the CC state path).
package aurora_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;  // idle
    localparam logic [7:0] K27_7 = 8'hFB;  // start of channel PDU (SCP)
    localparam logic [7:0] K29_7 = 8'hFD;  // end of channel PDU (ECP)
    localparam logic [7:0] K28_0 = 8'h1C;  // pad
    localparam logic [7:0] K23_7 = 8'hF7;  // clock compensation

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        OS   = 3'd1,
        SOF  = 3'd2,
        DATA = 3'd3,
        EOF  = 3'd4,
        CC   = 3'd5
    } striper_state_e;

endpackage

// File: rtl/aurora_cc_timer.sv
// Clock-compensation timer for the Aurora lane striper.
// Free-running counter that raises cc_due every CC_PERIOD cycles; cc_due
// stays up until the striper acknowledges it by entering its CC state.
// Only instantiated when AURORA_STRIPER_CC_EN is defined.
module aurora_cc_timer #(
    parameter int CC_PERIOD = 5000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_cc_due
);

    localparam int CW = $clog2(CC_PERIOD + 1);

    logic [CW-1:0] r_cnt;
    logic          r_due;

    // Period counter; a wrap sets the request, CC entry clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_due <= 1'b0;
        end else begin
            if (r_cnt == CW'(CC_PERIOD - 1)) begin
                r_cnt <= '0;
                r_due <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CW'(1);
                if (i_clr) begin
                    r_due <= 1'b0;
                end
            end
        end
    end

    assign o_cc_due = r_due;

endmodule

// File: rtl/aurora_lane_striper.sv
// Multi-lane Aurora 8b/10b TX framer.
// Emits idles, ordered sets and SCP/ECP-framed user data, byte-striped
// across a runtime-selected number of active lanes. All lane outputs are
// registered; s_axis_tready is decoded from the current state.
// Optional feature macro: AURORA_STRIPER_CC_EN (periodic CC sequences).
module aurora_lane_striper
    import aurora_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int MAX_OS_LEN = 4,
    parameter int CC_PERIOD  = 5000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [$clog2(NUM_LANES):0]    active_lanes,
    input  logic                          os_req,
    input  logic [MAX_OS_LEN*8-1:0]       os_bytes,
    input  logic [MAX_OS_LEN-1:0]         os_kmask,
    input  logic [$clog2(MAX_OS_LEN):0]   os_len,
    output logic                          os_ack,
    input  logic [NUM_LANES*8-1:0]        s_axis_tdata,
    input  logic [NUM_LANES-1:0]          s_axis_tkeep,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [NUM_LANES-1:0]          ctrl_out,
    output logic [NUM_LANES*8-1:0]        data_out
);

    localparam int AL_W  = $clog2(NUM_LANES) + 1;
    localparam int LEN_W = $clog2(MAX_OS_LEN) + 1;

    striper_state_e          r_state, w_next_state;
    logic [AL_W-1:0]         r_al, w_al_in, w_al_eff, w_n;
    logic [NUM_LANES-1:0]    w_lane_en, w_keep_eff;
    logic [MAX_OS_LEN*8-1:0] r_os_bytes;
    logic [MAX_OS_LEN-1:0]   r_os_kmask;
    logic [LEN_W-1:0]        r_os_last, r_os_idx, w_os_last_in;
    logic [7:0]              w_os_byte;
    logic                    w_os_k;
    logic [NUM_LANES-1:0]    r_ctrl, w_ctrl;
    logic [NUM_LANES*8-1:0]  r_data, w_data;
    logic                    r_os_ack, w_os_ack, w_latch_os;
    logic                    w_cc_due;

`ifdef AURORA_STRIPER_CC_EN
    striper_state_e r_ret_state;
    logic [1:0]     r_cc_cnt;
    logic           w_cc_enter;

    assign w_cc_enter = (r_state != CC) && (w_next_state == CC);

    aurora_cc_timer #(
        .CC_PERIOD (CC_PERIOD)
    ) u_cc_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_cc_enter),
        .o_cc_due (w_cc_due)
    );

    // Remember where to resume after CC and count its three cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ret_state <= IDLE;
            r_cc_cnt    <= '0;
        end else begin
            if (w_cc_enter) begin
                r_ret_state <= r_state;
            end
            r_cc_cnt <= (r_state == CC) ? r_cc_cnt + 2'd1 : '0;
        end
    end
`else
    assign w_cc_due = 1'b0;
`endif

    // Lane count clamp, active-lane mask and popcount of kept bytes.
    // IDLE uses the live (clamped) input so the mask tracks it immediately.
    always_comb begin
        if (active_lanes == '0) begin
            w_al_in = AL_W'(1);
        end else if (active_lanes > AL_W'(NUM_LANES)) begin
            w_al_in = AL_W'(NUM_LANES);
        end else begin
            w_al_in = active_lanes;
        end
        w_al_eff   = (r_state == IDLE) ? w_al_in : r_al;
        w_lane_en  = '0;
        w_keep_eff = '0;
        w_n        = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            w_lane_en[i]  = (AL_W'(i) < w_al_eff);
            w_keep_eff[i] = s_axis_tkeep[i] & w_lane_en[i];
            w_n           = w_n + AL_W'(w_keep_eff[i]);
        end
    end

    // Ordered-set length normalisation and current-byte select.
    always_comb begin
        if (os_len == '0) begin
            w_os_last_in = '0;
        end else if (os_len > LEN_W'(MAX_OS_LEN)) begin
            w_os_last_in = LEN_W'(MAX_OS_LEN - 1);
        end else begin
            w_os_last_in = os_len - LEN_W'(1);
        end
        w_os_byte = '0;
        w_os_k    = 1'b0;
        for (int unsigned k = 0; k < MAX_OS_LEN; k++) begin
            if (LEN_W'(k) == r_os_idx) begin
                w_os_byte = r_os_bytes[8*k +: 8];
                w_os_k    = r_os_kmask[k];
            end
        end
    end

    // Next state and next lane contents; inactive lanes are forced to zero last.
    always_comb begin
        w_next_state = r_state;
        w_data       = '0;
        w_ctrl       = '0;
        w_os_ack     = 1'b0;
        w_latch_os   = 1'b0;
        case (r_state)
            IDLE: begin
                for (int unsigned i = 0; i < NUM_LANES; i++) begin
                    w_data[8*i +: 8] = K28_5;
                end
                w_ctrl = '1;
                if (w_cc_due) begin
                    w_next_state = CC;
                end else if (os_req) begin
                    w_latch_os   = 1'b1;
                    w_os_ack     = 1'b1;
                    w_next_state = OS;
                end else if (s_axis_tvalid) begin
                    w_next_state = SOF;
                end
            end
            OS: begin
                for (int unsigned i = 0; i < NUM_LANES; i++) begin
                    w_data[8*i +: 8] = w_os_byte;
                    w_ctrl[i]        = w_os_k;
                end
                if (r_os_idx == r_os_last) begin
                    w_next_state = IDLE;
                end
            end
            SOF: begin
                for (int unsigned i = 0; i < NUM_LANES; i++) begin
                    w_data[8*i +: 8] = (i == 0) ? K27_7 : K28_0;
                end
                w_ctrl       = '1;
                w_next_state = DATA;
            end
            DATA: begin
                for (int unsigned i = 0; i < NUM_LANES; i++) begin
                    w_data[8*i +: 8] = K28_0;
                end
                w_ctrl = '1;
                if (w_cc_due) begin
                    w_next_state = CC;
                end else if (s_axis_tvalid) begin
                    for (int unsigned i = 0; i < NUM_LANES; i++) begin
                        if (w_keep_eff[i]) begin
                            w_data[8*i +: 8] = s_axis_tdata[8*i +: 8];
                            w_ctrl[i]        = 1'b0;
                        end else if (s_axis_tlast && (AL_W'(i) == w_n)) begin
                            w_data[8*i +: 8] = K29_7;
                        end
                    end
                    if (s_axis_tlast) begin
                        w_next_state = (w_n == r_al) ? EOF : IDLE;
                    end
                end
            end
            EOF: begin
                for (int unsigned i = 0; i < NUM_LANES; i++) begin
                    w_data[8*i +: 8] = (i == 0) ? K29_7 : K28_0;
                end
                w_ctrl       = '1;
                w_next_state = IDLE;
            end
            CC: begin
`ifdef AURORA_STRIPER_CC_EN
                for (int unsigned i = 0; i < NUM_LANES; i++) begin
                    w_data[8*i +: 8] = K23_7;
                end
                w_ctrl = '1;
                if (r_cc_cnt == 2'd2) begin
                    w_next_state = r_ret_state;
                end
`else
                w_next_state = IDLE;
`endif
            end
            default: w_next_state = IDLE;
        endcase
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (!w_lane_en[i]) begin
                w_data[8*i +: 8] = '0;
                w_ctrl[i]        = 1'b0;
            end
        end
    end

    // State, latched configuration and registered lane outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_al       <= '0;
            r_os_bytes <= '0;
            r_os_kmask <= '0;
            r_os_last  <= '0;
            r_os_idx   <= '0;
            r_ctrl     <= '0;
            r_data     <= '0;
            r_os_ack   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_ctrl   <= w_ctrl;
            r_data   <= w_data;
            r_os_ack <= w_os_ack;
            if (r_state == IDLE) begin
                r_al <= w_al_in;
            end
            if (w_latch_os) begin
                r_os_bytes <= os_bytes;
                r_os_kmask <= os_kmask;
                r_os_last  <= w_os_last_in;
            end
            r_os_idx <= (r_state == OS) ? r_os_idx + LEN_W'(1) : '0;
        end
    end

    assign s_axis_tready = (r_state == DATA) && !w_cc_due;
    assign os_ack        = r_os_ack;
    assign ctrl_out      = r_ctrl;
    assign data_out      = r_data;

endmodule
